cla_pipe_addsub: RTL and testbench
==================================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the integer datapath. WIDTH is split into STAGES equal segments. Each segment is a ripple of 4-bit lookahead blocks, and carries are registered between segments, so long adders meet timing at any width. A valid/ready handshake with global stall lets the ALU and the multi-cycle units back-pressure it. It also produces carry, overflow and zero flags and supports add-with-carry and subtract-with-borrow.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4*STAGES
- STAGES, 2, pipeline depth in cycles (1..WIDTH/4); segment width SEG = WIDTH/STAGES
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- in_valid_i  input  1  operands/op valid
- in_ready_o  output  1  block accepts when in_valid_i & in_ready_o
- term1_i  input  WIDTH  operand A
- term2_i  input  WIDTH  operand B
- op_i  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
- carry_i  input  1  carry-in for ADC/SBB; ignored for ADD/SUB
- flush_i  input  1  synchronous kill of all in-flight operations
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts
- result_o  output  WIDTH  sum/difference
- carry_o  output  1  carry-out of bit WIDTH-1
- overflow_o  output  1  signed overflow
- zero_o  output  1  result_o == 0

## Operation
- Effective B: `~term2_i` for SUB/SBB, else `term2_i`.
- Effective carry-in: ADD 0, SUB 1, ADC carry_i, SBB carry_i.
- The result is A + B_eff + cin modulo 2^WIDTH.
- carry_o is the true carry-out. For SUB/SBB, carry_o=1 means no borrow.
- overflow_o = (A[msb] == B_eff[msb]) & (result[msb] != A[msb]).
- Stage s (0..STAGES-1) adds bits [s*SEG +: SEG] using the carry registered by stage s-1; stage 0 uses the effective carry-in.
- Within a segment, SEG/4 lookahead blocks ripple their group carries combinationally.
- Upper operand slices are delayed through skew registers so they meet their carry.
- Completed lower result slices are delayed so the full result emerges aligned.
- Each stage holds a valid bit. Flags are computed from the final stage's registered values.
- Stall:
  - stall = out_valid_o & ~out_ready_i.
  - When stalled, every pipeline register, including skew registers and valid bits, holds its value.
  - in_ready_o = ~stall, which is combinational from out_valid_o and out_ready_i.
- Bubbles advance normally when the pipeline is not stalled, i.e. there is no compaction.
- Order is strictly FIFO. Throughput is one operation per cycle with out_ready_i held high.
- flush_i:
  - Clears all stage valid bits on the next edge and overrides an input accepted in the same cycle.
  - Data registers need not clear.
  - in_ready_o is unaffected.

## Timing
- Latency: an operation accepted at edge N is presented with out_valid_o=1 after edge N+STAGES, assuming no stall.
- With STAGES=1 the output is simply registered, with latency 1.
- Reset (rst_ni low, asynchronous):
  - out_valid_o=0 and all valid bits are 0.
  - result_o=0, carry_o=0, overflow_o=0, zero_o=0. zero_o is forced to 0 while out_valid_o=0.
  - in_ready_o=1 once out_valid_o=0.
- Reset asserted mid-operation discards all in-flight operations; nothing is emitted after release.
- result_o and the flags are stable while out_valid_o & ~out_ready_i.
- Simultaneous output pop and input accept in the same cycle is legal and does not stall.
- flush_i together with out_valid_o & out_ready_i: the current output is consumed, then nothing further from before the flush is emitted.
- Carries cross segment boundaries only through registers. The combinational path is at most SEG bits of block ripple.

## Structure
- The shared package `alu_pkg` holds:
  - the op enum: OP_ADD, OP_SUB, OP_ADC, OP_SBB
  - the CLA_BLK=4 constant
- Sub-module `cla_block`:
  - A 4-bit generate/propagate lookahead adder with group G/P outputs.
  - It is instantiated WIDTH/4 times through generate loops.
- The top level contains the skew/deskew shift registers, the valid chain, the stall logic and the flag logic.
- An elaboration-time check requires WIDTH % (4*STAGES) == 0 and STAGES >= 1.

## Test plan
- WIDTH=32, STAGES=2, ADD 0xFFFFFFFF+0x00000001 -> after 2 cycles: result 0x00000000, carry 1, zero 1, overflow 0.
- SUB 0x80000000-0x00000001 -> result 0x7FFFFFFF, carry 1, overflow 1. SUB 0x00000000-0x00000001 -> result 0xFFFFFFFF, carry 0.
- ADC 0x0000FFFF+0x00000000 with carry_i=1 -> result 0x00010000, which checks carry crossing the stage boundary at bit 16.
- Four back-to-back ops with out_ready_i low for 2 cycles mid-stream:
  - in_ready_o is low for those 2 cycles.
  - Held outputs are stable.
  - All four results arrive in order with none lost or duplicated.
- Two ops in flight, then flush_i for 1 cycle -> no out_valid_o. Separately, rst_ni pulsed low mid-stream -> all outputs 0 immediately, no stale results afterwards.
- Random constrained ops and operands for STAGES = 1, 2, 4, 8 with random out_ready_i, checked against a behavioural model for all results and flags.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: operation encoding and lookahead block width shared by the integer datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  localparam int CLA_BLK = 4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/cla_block.sv
`default_nettype none
// cla_block: 4-bit generate/propagate lookahead adder with group G/P for block-level rippling.
module cla_block
  import alu_pkg::*;
(
  input  logic [CLA_BLK-1:0] a_i,
  input  logic [CLA_BLK-1:0] b_i,
  input  logic               c_i,
  output logic [CLA_BLK-1:0] s_o,
  output logic               g_o,
  output logic               p_o
);

  logic [CLA_BLK-1:0] g;
  logic [CLA_BLK-1:0] p;
  logic [CLA_BLK-1:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;
  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;

endmodule : cla_block
`default_nettype wire

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// cla_pipe_addsub: pipelined carry-lookahead add/sub with valid/ready, global stall and flags.
// Each stage adds one SEG-bit segment; carries and operand skew cross stages only via registers.
module cla_pipe_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] term1_i,
  input  logic [WIDTH-1:0] term2_i,
  input  logic [1:0]       op_i,
  input  logic             carry_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int SEG  = WIDTH / ((STAGES < 1) ? 1 : STAGES);
  localparam int NBLK = SEG / CLA_BLK;

  if ((STAGES < 1) || ((WIDTH % (CLA_BLK * STAGES)) != 0)) begin : g_param_check
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4*STAGES and STAGES >= 1");
  end

  op_e              op_w;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             stall;

  always_comb begin
    op_w    = op_e'(op_i);
    b_eff   = term2_i;
    cin_eff = 1'b0;
    case (op_w)
      OP_ADD:  cin_eff = 1'b0;
      OP_SUB:  begin b_eff = ~term2_i; cin_eff = 1'b1;    end
      OP_ADC:  cin_eff = carry_i;
      OP_SBB:  begin b_eff = ~term2_i; cin_eff = carry_i; end
      default: cin_eff = 1'b0;
    endcase
  end

  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * SEG;
    localparam int IW = WIDTH - LO;
    // The last stage only keeps the operand MSBs needed for the overflow flag.
    localparam int RW = (s == STAGES - 1) ? 1 : IW - SEG;

    logic [IW-1:0]     a_in;
    logic [IW-1:0]     b_in;
    logic              cin;
    logic              vld_in;
    logic [NBLK:0]     gc;
    logic [SEG-1:0]    seg_sum;
    logic [RW-1:0]     a_d;
    logic [RW-1:0]     b_d;
    logic [RW-1:0]     a_q;
    logic [RW-1:0]     b_q;
    logic [LO+SEG-1:0] sum_d;
    logic [LO+SEG-1:0] sum_q;
    logic              cy_q;
    logic              vld_q;

    if (s == 0) begin : g_head
      assign a_in   = term1_i;
      assign b_in   = b_eff;
      assign cin    = cin_eff;
      assign vld_in = in_valid_i;
      assign sum_d  = seg_sum;
    end else begin : g_body
      assign a_in   = g_stage[s-1].a_q;
      assign b_in   = g_stage[s-1].b_q;
      assign cin    = g_stage[s-1].cy_q;
      assign vld_in = g_stage[s-1].vld_q;
      assign sum_d  = {seg_sum, g_stage[s-1].sum_q};
    end

    if (s == STAGES - 1) begin : g_tail
      assign a_d = a_in[IW-1];
      assign b_d = b_in[IW-1];
    end else begin : g_skew
      assign a_d = a_in[IW-1:SEG];
      assign b_d = b_in[IW-1:SEG];
    end

    assign gc[0] = cin;
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
      logic grp_g;
      logic grp_p;

      cla_block u_blk (
        .a_i (a_in[k*CLA_BLK +: CLA_BLK]),
        .b_i (b_in[k*CLA_BLK +: CLA_BLK]),
        .c_i (gc[k]),
        .s_o (seg_sum[k*CLA_BLK +: CLA_BLK]),
        .g_o (grp_g),
        .p_o (grp_p)
      );

      assign gc[k+1] = grp_g | (grp_p & gc[k]);
    end

    // Flush wins over stall so killed operations never reach the output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        sum_q <= '0;
      end else begin
        if (flush_i) begin
          vld_q <= 1'b0;
        end else if (!stall) begin
          vld_q <= vld_in;
        end
        if (!stall) begin
          cy_q  <= gc[NBLK];
          a_q   <= a_d;
          b_q   <= b_d;
          sum_q <= sum_d;
        end
      end
    end
  end

  assign out_valid_o = g_stage[STAGES-1].vld_q;
  assign result_o    = g_stage[STAGES-1].sum_q;
  assign carry_o     = g_stage[STAGES-1].cy_q;
  assign overflow_o  = (g_stage[STAGES-1].a_q[0] == g_stage[STAGES-1].b_q[0]) &
                       (result_o[WIDTH-1] != g_stage[STAGES-1].a_q[0]);
  assign zero_o      = out_valid_o & ~(|result_o);

endmodule : cla_pipe_addsub
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// tb_cla_pipe_addsub: directed vectors plus randomized traffic on STAGES = 1, 2, 4, 8 instances,
// checked against an arithmetic reference model and an in-order expectation queue.
module tb_cla_pipe_addsub;

  localparam int W  = 32;
  localparam int NI = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv    [NI];
  logic         flush [NI];
  logic         ordy  [NI];
  logic         cin   [NI];
  logic [1:0]   op    [NI];
  logic [W-1:0] ta    [NI];
  logic [W-1:0] tb    [NI];
  logic         ir    [NI];
  logic         ov    [NI];
  logic         co    [NI];
  logic         vo    [NI];
  logic         zo    [NI];
  logic [W-1:0] res   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cla_pipe_addsub #(.WIDTH(W), .STAGES(1 << g)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (iv[g]),
      .in_ready_o  (ir[g]),
      .term1_i     (ta[g]),
      .term2_i     (tb[g]),
      .op_i        (op[g]),
      .carry_i     (cin[g]),
      .flush_i     (flush[g]),
      .out_valid_o (ov[g]),
      .out_ready_i (ordy[g]),
      .result_o    (res[g]),
      .carry_o     (co[g]),
      .overflow_o  (vo[g]),
      .zero_o      (zo[g])
    );
  end

  int          pass_n = 0;
  int          total_n = 0;
  int          pops = 0;
  exp_t        expq[$];
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci);
    exp_t       m;
    logic [W:0] s;
    logic [W-1:0] be;
    logic       c0;
    logic       is_sub;
    is_sub = (o == 2'd1) || (o == 2'd3);
    be = is_sub ? ~b : b;
    c0 = (o == 2'd0) ? 1'b0 : (o == 2'd1) ? 1'b1 : ci;
    s  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
    m.r = s[W-1:0];
    m.c = s[W];
    m.v = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
    m.z = (s[W-1:0] == '0);
    return m;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Called at a negedge with this cycle's inputs applied; returns whether the input was accepted.
  task automatic step(input int k, output logic acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (prev_stall) begin
      chk("stall_hold_valid", {63'd0, ov[k]}, 64'd1);
      chk("stall_hold_data", {29'd0, res[k], co[k], vo[k], zo[k]}, {29'd0, prev_out});
    end
    if (!ov[k]) chk("zero_gated", {63'd0, zo[k]}, 64'd0);
    chk("in_ready", {63'd0, ir[k]}, {63'd0, !(ov[k] && !ordy[k])});
    if (ov[k] && ordy[k]) begin
      if (expq.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        pops++;
        chk("result", {32'd0, res[k]}, {32'd0, e.r});
        chk("carry", {63'd0, co[k]}, {63'd0, e.c});
        chk("overflow", {63'd0, vo[k]}, {63'd0, e.v});
        chk("zero", {63'd0, zo[k]}, {63'd0, e.z});
      end
    end
    if (flush[k]) begin
      expq.delete();
    end else if (iv[k] && ir[k]) begin
      expq.push_back(model(op[k], ta[k], tb[k], cin[k]));
      acc = 1'b1;
    end
    prev_stall = ov[k] && !ordy[k] && !flush[k];
    prev_out   = {res[k], co[k], vo[k], zo[k]};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int k, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci);
    iv[k] = 1'b1; op[k] = o; ta[k] = a; tb[k] = b; cin[k] = ci;
  endtask

  vec_t        vt[8];
  logic [1:0]  sops[4];
  logic [W-1:0] sa[4];
  logic [W-1:0] sb[4];
  logic        acc;
  int          idx;

  initial begin
    vt[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[2] = '{2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vt[3] = '{2'd2, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vt[4] = '{2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[5] = '{2'd3, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vt[6] = '{2'd0, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
    vt[7] = '{2'd1, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; flush[k] = 1'b0; ordy[k] = 1'b1; cin[k] = 1'b0;
      op[k] = 2'd0; ta[k] = '0; tb[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_valid", {63'd0, ov[k]}, 64'd0);
      chk("reset_result", {32'd0, res[k]}, 64'd0);
      chk("reset_flags", {61'd0, co[k], vo[k], zo[k]}, 64'd0);
      chk("reset_ready", {63'd0, ir[k]}, 64'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors on the 2-stage instance, one at a time with latency checks.
    foreach (vt[i]) begin
      set_op(1, vt[i].op, vt[i].a, vt[i].b, vt[i].ci);
      step(1, acc);
      chk("vec_accept", {63'd0, acc}, 64'd1);
      iv[1] = 1'b0;
      chk("vec_latency_early", {63'd0, ov[1]}, 64'd0);
      step(1, acc);
      chk("vec_valid", {63'd0, ov[1]}, 64'd1);
      chk("vec_result", {32'd0, res[1]}, {32'd0, vt[i].r});
      chk("vec_flags", {61'd0, co[1], vo[1], zo[1]}, {61'd0, vt[i].c, vt[i].v, vt[i].z});
      step(1, acc);
    end

    // Four back-to-back ops with the consumer stalling for two cycles.
    sops[0] = 2'd0; sa[0] = 32'h0000_0010; sb[0] = 32'h0000_0001;
    sops[1] = 2'd1; sa[1] = 32'h0000_0020; sb[1] = 32'h0000_0002;
    sops[2] = 2'd2; sa[2] = 32'h1234_FFFF; sb[2] = 32'h0000_0001;
    sops[3] = 2'd3; sa[3] = 32'h0000_0040; sb[3] = 32'h0000_0004;
    pops = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) set_op(1, sops[idx], sa[idx], sb[idx], 1'b1);
      else iv[1] = 1'b0;
      ordy[1] = !(c == 2 || c == 3);
      #1;
      if (c == 2 || c == 3) chk("stall_in_ready_low", {63'd0, ir[1]}, 64'd0);
      step(1, acc);
      if (acc) idx++;
    end
    chk("stall_all_out", pops, 64'd4);
    chk("stall_queue_empty", expq.size(), 64'd0);

    // Flush with two ops in flight on the 4-stage instance.
    for (int c = 0; c < 2; c++) begin
      set_op(2, 2'd0, 32'h0000_0100 + c, 32'h1, 1'b0);
      step(2, acc);
    end
    iv[2] = 1'b0;
    flush[2] = 1'b1;
    step(2, acc);
    flush[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("flush_no_valid", {63'd0, ov[2]}, 64'd0);
      step(2, acc);
    end

    // Flush while the 2-stage output is being consumed: that output survives, the next does not.
    pops = 0;
    for (int c = 0; c < 2; c++) begin
      set_op(1, 2'd0, 32'h0000_0200 + c, 32'h2, 1'b0);
      step(1, acc);
    end
    iv[1] = 1'b0;
    flush[1] = 1'b1;
    step(1, acc);
    flush[1] = 1'b0;
    for (int c = 0; c < 6; c++) step(1, acc);
    chk("flush_pop_count", pops, 64'd1);

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 2; c++) begin
      set_op(2, 2'd1, 32'h0000_0300 + c, 32'h3, 1'b0);
      step(2, acc);
    end
    iv[2] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, ov[2]}, 64'd0);
    chk("arst_result", {32'd0, res[2]}, 64'd0);
    chk("arst_flags", {61'd0, co[2], vo[2], zo[2]}, 64'd0);
    chk("arst_ready", {63'd0, ir[2]}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    expq.delete();
    prev_stall = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("arst_no_stale", {63'd0, ov[2]}, 64'd0);
      step(2, acc);
    end

    // Randomized traffic on every depth.
    for (int k = 0; k < NI; k++) begin
      expq.delete();
      prev_stall = 1'b0;
      for (int c = 0; c < 600; c++) begin
        iv[k]    = ($urandom_range(0, 9) < 7);
        op[k]    = 2'($urandom_range(0, 3));
        ta[k]    = pick();
        tb[k]    = pick();
        cin[k]   = 1'($urandom_range(0, 1));
        ordy[k]  = ($urandom_range(0, 9) < 7);
        flush[k] = ($urandom_range(0, 49) == 0);
        step(k, acc);
      end
      iv[k] = 1'b0; flush[k] = 1'b0; ordy[k] = 1'b1;
      for (int c = 0; c < 20; c++) step(k, acc);
      chk("drain_empty", expq.size(), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule : tb_cla_pipe_addsub
`default_nettype wire
